pipeline_stall_controller: RTL
==============================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter OPCODE_W, default 5, opcode width.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, register address width.
REQ-003 SHALL have parameter INT_SAVE_CYCLES, default 2, freeze cycles for interrupt context save (legal 1..15).
REQ-004 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before error (legal 1..255).
REQ-005 Ports: clk  in  1  single clock, all state on rising edge.
REQ-006 Ports: rst  in  1  asynchronous, active-low reset.
REQ-007 Ports: id_valid  in  1  decode stage holds a real instruction.
REQ-008 Ports: id_rsrc, id_rdst  in  REG_ADDR_W  decode-stage source/destination addresses.
REQ-009 Ports: ex_opcode  in  OPCODE_W  execute-stage opcode; ex_rdst  in  REG_ADDR_W  its destination.
REQ-010 Ports: ex_branch_taken  in  1; mem_busy  in  1  data memory not ready; int_req  in  1  level interrupt request.
REQ-011 Ports: freeze_pc, freeze_if_id, freeze_id_ex, bubble_id_ex, flush_if_id  out  1  pipeline controls.
REQ-012 Ports: int_ack  out  1  one-cycle pulse; mem_timeout  out  1  sticky error.
REQ-013 Ports: stats_clr  in  1; stall_count  out  16  frozen-cycle count.

Function
REQ-014 Load-use hazard SHALL be: id_valid and ex_opcode in {LDD 5'b10010, POP 5'b10000} and (id_rsrc==ex_rdst or id_rdst==ex_rdst).
REQ-015 FSM states SHALL be IDLE, MEM_WAIT, INT_FLUSH, INT_SAVE; outputs default 0 unless stated.
REQ-016 In IDLE, event priority SHALL be ex_branch_taken > mem_busy > load-use > int_req; only the highest acts.
REQ-017 IDLE+branch: flush_if_id=1, bubble_id_ex=1 same cycle; stay IDLE.
REQ-018 IDLE+mem_busy: freeze_pc, freeze_if_id, freeze_id_ex =1 same cycle; next MEM_WAIT, timeout counter=1.
REQ-019 IDLE+load-use: freeze_pc=1, freeze_if_id=1, bubble_id_ex=1 same cycle (one-cycle stall); stay IDLE.
REQ-020 IDLE+int_req: next INT_FLUSH.
REQ-021 MEM_WAIT: while mem_busy, all three freezes=1 and counter increments; mem_busy=0 -> freezes 0, next IDLE; ex_branch_taken ignored.
REQ-022 MEM_WAIT counter reaching MEM_TIMEOUT with mem_busy=1 SHALL set mem_timeout and return to IDLE.
REQ-023 INT_FLUSH (1 cycle): flush_if_id=1, bubble_id_ex=1, freeze_pc=1; next INT_SAVE with save counter=0.
REQ-024 INT_SAVE: freeze_pc=1 each cycle; after INT_SAVE_CYCLES cycles assert int_ack on the last cycle and return IDLE.
REQ-025 int_req deasserted during INT_FLUSH/INT_SAVE SHALL NOT abort the sequence; mem_busy during INT_SAVE SHALL additionally assert freeze_if_id and freeze_id_ex and extend INT_SAVE until mem_busy=0.
REQ-026 stall_count SHALL increment, saturating at 16'hFFFF, on every cycle freeze_pc=1; stats_clr SHALL zero it (clear wins over increment).

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, all counters 0, mem_timeout 0, stall_count 0, all outputs 0.
REQ-028 Reset mid INT_SAVE or MEM_WAIT SHALL abort with no int_ack pulse.
REQ-029 mem_timeout SHALL clear only by reset.

Configuration
REQ-030 Macro STALL_STATS_EN defined: stall_count counter and stats_clr behaviour present per REQ-026.
REQ-031 Macro undefined: ports retained, stall_count tied 16'h0000, stats_clr ignored, no counter flops.

Structure
REQ-032 Package pipeline_ctrl_pkg SHALL hold OPCODE_LDD, OPCODE_POP, state enum, width constants.
REQ-033 Sub-module load_use_detect SHALL implement REQ-014 combinationally.

Verification
REQ-034 ex_opcode=10010, ex_rdst=3, id_rsrc=3, id_valid=1 -> freeze_pc, freeze_if_id, bubble_id_ex high exactly 1 cycle.
REQ-035 Same as REQ-034 with ex_branch_taken=1 -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0.
REQ-036 mem_busy high 4 cycles -> freezes high 4 cycles, IDLE on 5th; held 300 cycles -> mem_timeout=1 at cycle 255.
REQ-037 int_req pulse 1 cycle, INT_SAVE_CYCLES=2 -> INT_FLUSH, 2 INT_SAVE cycles, int_ack on 4th cycle after request.
REQ-038 rst low during INT_SAVE -> outputs 0 immediately, no int_ack; STALL_STATS_EN: 3 frozen cycles -> stall_count=3, stats_clr -> 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: opcode encodings,
// controller state enum and counter widths.
package pipeline_ctrl_pkg;

    localparam int OPCODE_W_DEF   = 5;
    localparam int REG_ADDR_W_DEF = 3;
    localparam int MEM_CNT_W      = 8;   // holds MEM_TIMEOUT up to 255
    localparam int SAVE_CNT_W     = 4;   // holds INT_SAVE_CYCLES up to 15
    localparam int STALL_CNT_W    = 16;

    // Execute-stage opcodes that return their result late (load-use sources)
    localparam logic [4:0] OPCODE_LDD = 5'b10010;
    localparam logic [4:0] OPCODE_POP = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        INT_FLUSH,
        INT_SAVE
    } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the instruction in decode reads or
// writes the register that a load/pop in execute has not yet produced.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = OPCODE_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rsrc,
    input  logic [REG_ADDR_W-1:0] id_rdst,
    input  logic [OPCODE_W-1:0]   ex_opcode,
    input  logic [REG_ADDR_W-1:0] ex_rdst,
    output logic                  hazard
);

    logic is_late_op;
    logic addr_hit;

    assign is_late_op = (ex_opcode == OPCODE_W'(OPCODE_LDD)) ||
                        (ex_opcode == OPCODE_W'(OPCODE_POP));
    assign addr_hit   = (id_rsrc == ex_rdst) || (id_rdst == ex_rdst);
    assign hazard     = id_valid && is_late_op && addr_hit;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: resolves branch flushes, memory waits,
// load-use stalls and the interrupt flush/context-save sequence.
// Optional build macro STALL_STATS_EN adds the frozen-cycle counter
// (stall_count / stats_clr); without it stall_count reads 0.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int OPCODE_W        = OPCODE_W_DEF,
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int INT_SAVE_CYCLES = 2,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rsrc,
    input  logic [REG_ADDR_W-1:0]  id_rdst,
    input  logic [OPCODE_W-1:0]    ex_opcode,
    input  logic [REG_ADDR_W-1:0]  ex_rdst,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    input  logic                   int_req,
    output logic                   freeze_pc,
    output logic                   freeze_if_id,
    output logic                   freeze_id_ex,
    output logic                   bubble_id_ex,
    output logic                   flush_if_id,
    output logic                   int_ack,
    output logic                   mem_timeout,
    input  logic                   stats_clr,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [MEM_CNT_W:0]    TIMEOUT_LIM = (MEM_CNT_W+1)'(MEM_TIMEOUT);
    localparam logic [SAVE_CNT_W-1:0] SAVE_LAST   = SAVE_CNT_W'(INT_SAVE_CYCLES - 1);

    state_e                state, state_next;
    logic [MEM_CNT_W-1:0]  mem_cnt, mem_cnt_next;
    logic [MEM_CNT_W:0]    mem_cnt_inc;
    logic [SAVE_CNT_W-1:0] save_cnt, save_cnt_next;
    logic                  timeout_set;
    logic                  hazard;
    logic                  f_pc, f_if_id, f_id_ex, bub, flush, ack;

    load_use_detect #(
        .OPCODE_W   (OPCODE_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_valid  (id_valid),
        .id_rsrc   (id_rsrc),
        .id_rdst   (id_rdst),
        .ex_opcode (ex_opcode),
        .ex_rdst   (ex_rdst),
        .hazard    (hazard)
    );

    assign mem_cnt_inc = {1'b0, mem_cnt} + 1'b1;

    // Next-state and same-cycle control decode from current state and events
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_next    = state;
        mem_cnt_next  = mem_cnt;
        save_cnt_next = save_cnt;
        timeout_set   = 1'b0;
        f_pc          = 1'b0;
        f_if_id       = 1'b0;
        f_id_ex       = 1'b0;
        bub           = 1'b0;
        flush         = 1'b0;
        ack           = 1'b0;
        unique case (state)
            IDLE: begin
                if (ex_branch_taken) begin
                    flush = 1'b1;
                    bub   = 1'b1;
                end else if (mem_busy) begin
                    f_pc         = 1'b1;
                    f_if_id      = 1'b1;
                    f_id_ex      = 1'b1;
                    state_next   = MEM_WAIT;
                    mem_cnt_next = MEM_CNT_W'(1);
                end else if (hazard) begin
                    f_pc    = 1'b1;
                    f_if_id = 1'b1;
                    bub     = 1'b1;
                end else if (int_req) begin
                    state_next = INT_FLUSH;
                end
            end
            MEM_WAIT: begin
                // branches cannot act while the memory holds the pipe
                if (mem_busy) begin
                    f_pc    = 1'b1;
                    f_if_id = 1'b1;
                    f_id_ex = 1'b1;
                    if (mem_cnt_inc >= TIMEOUT_LIM) begin
                        timeout_set  = 1'b1;
                        state_next   = IDLE;
                        mem_cnt_next = '0;
                    end else begin
                        mem_cnt_next = mem_cnt_inc[MEM_CNT_W-1:0];
                    end
                end else begin
                    state_next   = IDLE;
                    mem_cnt_next = '0;
                end
            end
            INT_FLUSH: begin
                flush         = 1'b1;
                bub           = 1'b1;
                f_pc          = 1'b1;
                state_next    = INT_SAVE;
                save_cnt_next = '0;
            end
            INT_SAVE: begin
                f_pc = 1'b1;
                if (mem_busy) begin
                    // a pending memory access stretches the save window
                    f_if_id = 1'b1;
                    f_id_ex = 1'b1;
                    if (save_cnt < SAVE_LAST) save_cnt_next = save_cnt + 1'b1;
                end else if (save_cnt >= SAVE_LAST) begin
                    ack           = 1'b1;
                    state_next    = IDLE;
                    save_cnt_next = '0;
                end else begin
                    save_cnt_next = save_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_cnt     <= '0;
            save_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            mem_cnt  <= mem_cnt_next;
            save_cnt <= save_cnt_next;
            if (timeout_set) mem_timeout <= 1'b1;
        end
    end

    // Controls are decoded combinationally; reset forces them low at once
    assign freeze_pc    = rst & f_pc;
    assign freeze_if_id = rst & f_if_id;
    assign freeze_id_ex = rst & f_id_ex;
    assign bubble_id_ex = rst & bub;
    assign flush_if_id  = rst & flush;
    assign int_ack      = rst & ack;

`ifdef STALL_STATS_EN
    // Saturating count of cycles with the PC frozen; clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stats_clr) begin
            stall_count <= '0;
        end else if (freeze_pc && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stall_count      = '0;
`endif

endmodule
